// File: rtl/refill_burst_seq_pkg.sv
// rtl/refill_burst_seq_pkg.sv - shared geometry defaults and state encoding for the refill burst sequencer
package refill_burst_seq_pkg;

    localparam int CFG_WORDS     = 4;
    localparam int CFG_IDX_BITS  = 2;
    localparam int CFG_BLK_BITS  = 6;
    localparam int CFG_DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_RF   = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/refill_addr_gen.sv
// rtl/refill_addr_gen.sv - word index counter and block-address mux producing the memory word address
module refill_addr_gen
    import refill_burst_seq_pkg::*;
#(
    parameter int WORDS    = CFG_WORDS,
    parameter int IDX_BITS = CFG_IDX_BITS,
    parameter int BLK_BITS = CFG_BLK_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_clr,
    input  logic                         i_inc,
    input  logic                         i_active,
    input  logic                         i_sel_victim,
    input  logic [BLK_BITS-1:0]          i_fill_blk,
    input  logic [BLK_BITS-1:0]          i_victim_blk,
    output logic [BLK_BITS+IDX_BITS-1:0] o_mem_addr,
    output logic [IDX_BITS-1:0]          o_word_idx,
    output logic                         o_last
);

    logic [IDX_BITS-1:0] r_idx;
    logic [BLK_BITS-1:0] w_blk;

    // Index wraps naturally at WORDS because WORDS == 2**IDX_BITS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_inc) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    assign w_blk      = i_sel_victim ? i_victim_blk : i_fill_blk;
    assign o_mem_addr = i_active ? {w_blk, r_idx} : '0;
    assign o_word_idx = r_idx;
    assign o_last     = (r_idx == IDX_BITS'(WORDS - 1));

endmodule

// File: rtl/refill_burst_seq.sv
// rtl/refill_burst_seq.sv - cache block refill sequencer paced by divider ticks; WRITEBACK_EN adds dirty-victim writeback
module refill_burst_seq
    import refill_burst_seq_pkg::*;
#(
    parameter int WORDS     = CFG_WORDS,
    parameter int IDX_BITS  = CFG_IDX_BITS,
    parameter int BLK_BITS  = CFG_BLK_BITS,
    parameter int DATA_BITS = CFG_DATA_BITS
) (
    input  logic                         clk,
    input  logic                         r,
    input  logic                         req,
    input  logic                         dirty,
    input  logic [BLK_BITS-1:0]          fill_blk,
    input  logic [BLK_BITS-1:0]          victim_blk,
    input  logic                         tick,
    input  logic [DATA_BITS-1:0]         mem_rdata,
    input  logic [DATA_BITS-1:0]         cache_rdata,
    output logic                         busy,
    output logic                         done,
    output logic                         div_en,
    output logic                         div_r,
    output logic                         mem_rd,
    output logic                         mem_wr,
    output logic [BLK_BITS+IDX_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0]         mem_wdata,
    output logic [IDX_BITS-1:0]          word_idx,
    output logic                         cache_we,
    output logic [DATA_BITS-1:0]         cache_wdata
);

    seq_state_t          r_state;
    logic [BLK_BITS-1:0] r_fill_blk;
    logic [BLK_BITS-1:0] w_victim_blk;
    logic                w_accept;
    logic                w_active;
    logic                w_in_wb;
    logic                w_in_rf;
    logic                w_step;
    logic                w_last;

    assign w_accept = (r_state == ST_IDLE) && req;
    assign w_in_rf  = (r_state == ST_RF);
    assign w_active = w_in_wb || w_in_rf;
    assign w_step   = w_active && tick;

`ifdef WRITEBACK_EN
    logic [BLK_BITS-1:0] r_victim_blk;

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            r_victim_blk <= '0;
        end else if (w_accept) begin
            r_victim_blk <= victim_blk;
        end
    end

    assign w_in_wb      = (r_state == ST_WB);
    assign w_victim_blk = r_victim_blk;
    assign mem_wr       = w_in_wb;
    assign mem_wdata    = w_in_wb ? cache_rdata : '0;
`else
    // Write-through build: victim-side inputs have no consumer.
    logic w_unused;
    assign w_unused     = ^{dirty, victim_blk, cache_rdata};
    assign w_in_wb      = 1'b0;
    assign w_victim_blk = '0;
    assign mem_wr       = 1'b0;
    assign mem_wdata    = '0;
`endif

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            r_state    <= ST_IDLE;
            r_fill_blk <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_fill_blk <= fill_blk;
`ifdef WRITEBACK_EN
                        r_state    <= dirty ? ST_WB : ST_RF;
`else
                        r_state    <= ST_RF;
`endif
                    end
                end
`ifdef WRITEBACK_EN
                ST_WB: begin
                    if (tick && w_last) begin
                        r_state <= ST_RF;
                    end
                end
`endif
                ST_RF: begin
                    if (tick && w_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    refill_addr_gen #(
        .WORDS    (WORDS),
        .IDX_BITS (IDX_BITS),
        .BLK_BITS (BLK_BITS)
    ) u_addr_gen (
        .clk          (clk),
        .rst          (r),
        .i_clr        (w_accept),
        .i_inc        (w_step),
        .i_active     (w_active),
        .i_sel_victim (w_in_wb),
        .i_fill_blk   (r_fill_blk),
        .i_victim_blk (w_victim_blk),
        .o_mem_addr   (mem_addr),
        .o_word_idx   (word_idx),
        .o_last       (w_last)
    );

    // div_r is gated by reset so every output reads zero while r is held.
    assign div_r       = w_accept && !r;
    assign busy        = w_active;
    assign div_en      = w_active;
    assign done        = (r_state == ST_DONE);
    assign mem_rd      = w_in_rf;
    assign cache_we    = w_in_rf && tick;
    assign cache_wdata = w_in_rf ? mem_rdata : '0;

endmodule

// File: tb/tb_refill_burst_seq.sv
// tb/tb_refill_burst_seq.sv - randomized self-checking bench for refill_burst_seq against a transfer-level model
module tb_refill_burst_seq;

`ifdef WRITEBACK_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       r;
    logic       req;
    logic       dirty;
    logic [5:0] fill_blk;
    logic [5:0] victim_blk;
    logic       tick;
    logic [7:0] mem_rdata;
    logic [7:0] cache_rdata;
    logic       busy;
    logic       done;
    logic       div_en;
    logic       div_r;
    logic       mem_rd;
    logic       mem_wr;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [1:0] word_idx;
    logic       cache_we;
    logic [7:0] cache_wdata;

    int n_vec = 0;
    int n_err = 0;

    refill_burst_seq dut (
        .clk         (clk),
        .r           (r),
        .req         (req),
        .dirty       (dirty),
        .fill_blk    (fill_blk),
        .victim_blk  (victim_blk),
        .tick        (tick),
        .mem_rdata   (mem_rdata),
        .cache_rdata (cache_rdata),
        .busy        (busy),
        .done        (done),
        .div_en      (div_en),
        .div_r       (div_r),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .word_idx    (word_idx),
        .cache_we    (cache_we),
        .cache_wdata (cache_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_div_en"}, div_en, 0);
        chk({tag, "_div_r"}, div_r, 0);
        chk({tag, "_mem_rd"}, mem_rd, 0);
        chk({tag, "_mem_wr"}, mem_wr, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_word_idx"}, word_idx, 0);
        chk({tag, "_cache_we"}, cache_we, 0);
        chk({tag, "_cache_wdata"}, cache_wdata, 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            req         = 1'b0;
            tick        = 1'($urandom);
            fill_blk    = 6'($urandom);
            victim_blk  = 6'($urandom);
            dirty       = 1'($urandom);
            mem_rdata   = 8'($urandom);
            cache_rdata = 8'($urandom);
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_div_r", div_r, 0);
            chk("idle_cache_we", cache_we, 0);
            chk("idle_word_idx", word_idx, 0);
            chk("idle_mem_rd", mem_rd, 0);
            chk("idle_mem_wr", mem_wr, 0);
        end
    endtask

    // One full transfer: accept cycle, optional writeback burst, refill burst, DONE cycle.
    task automatic run_xfer(input logic [5:0] fb, input logic [5:0] vb, input bit d,
                            input int per, input bit hold);
        bit         wb;
        int         nops;
        int         k;
        int         cyc;
        bit         in_wb;
        logic [1:0] idx;
        logic [7:0] exp_addr;
        wb   = d && WB_EN;
        nops = wb ? 2 * 4 : 4;
        k    = 0;
        cyc  = 0;

        @(posedge clk); #1;
        req         = 1'b1;
        fill_blk    = fb;
        victim_blk  = vb;
        dirty       = d;
        tick        = 1'($urandom);
        mem_rdata   = 8'($urandom);
        cache_rdata = 8'($urandom);
        @(negedge clk);
        chk("acc_div_r", div_r, 1);
        chk("acc_busy", busy, 0);
        chk("acc_div_en", div_en, 0);
        chk("acc_cache_we", cache_we, 0);
        chk("acc_word_idx", word_idx, 0);

        while (k < nops) begin
            @(posedge clk); #1;
            req         = hold;
            fill_blk    = 6'($urandom);
            victim_blk  = 6'($urandom);
            dirty       = 1'($urandom);
            cyc++;
            tick        = ((cyc % per) == 0);
            mem_rdata   = 8'($urandom);
            cache_rdata = 8'($urandom);
            @(negedge clk);
            in_wb    = (k < (wb ? 4 : 0));
            idx      = 2'(k % 4);
            exp_addr = {in_wb ? vb : fb, idx};
            chk("x_busy", busy, 1);
            chk("x_div_en", div_en, 1);
            chk("x_div_r", div_r, 0);
            chk("x_done", done, 0);
            chk("x_mem_wr", mem_wr, in_wb);
            chk("x_mem_rd", mem_rd, !in_wb);
            chk("x_mem_addr", mem_addr, exp_addr);
            chk("x_word_idx", word_idx, idx);
            chk("x_cache_we", cache_we, !in_wb && tick);
            if (in_wb) begin
                chk("wb_mem_wdata", mem_wdata, cache_rdata);
            end else begin
                chk("rf_mem_wdata", mem_wdata, 0);
                if (tick) chk("rf_cache_wdata", cache_wdata, mem_rdata);
            end
            if (tick) k++;
        end

        @(posedge clk); #1;
        req  = hold;
        tick = 1'($urandom);
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_div_en", div_en, 0);
        chk("done_div_r", div_r, 0);
        chk("done_cache_we", cache_we, 0);
        chk("done_mem_rd", mem_rd, 0);
        chk("done_mem_wr", mem_wr, 0);
        chk("done_word_idx", word_idx, 0);
    endtask

    initial begin
        r           = 1'b1;
        req         = 1'b0;
        dirty       = 1'b0;
        fill_blk    = '0;
        victim_blk  = '0;
        tick        = 1'b0;
        mem_rdata   = '0;
        cache_rdata = '0;
        #2;
        check_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        r = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        idle_cycles(3);

        run_xfer(6'h15, 6'h00, 1'b0, 3, 1'b0);
        idle_cycles(2);

        run_xfer(6'h15, 6'h2A, 1'b1, 2, 1'b0);
        idle_cycles(2);

        run_xfer(6'($urandom), 6'($urandom), 1'($urandom), 2, 1'b1);
        run_xfer(6'($urandom), 6'($urandom), 1'($urandom), 1, 1'b0);
        idle_cycles(2);

        // Abort mid-refill at word 2 with an asynchronous reset pulse.
        @(posedge clk); #1;
        req = 1'b1; fill_blk = 6'h33; dirty = 1'b0; tick = 1'b0;
        @(posedge clk); #1;
        req = 1'b0; tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        @(negedge clk);
        chk("pre_abort_idx", word_idx, 2);
        chk("pre_abort_mem_rd", mem_rd, 1);
        chk("pre_abort_addr", mem_addr, {6'h33, 2'd2});
        #2;
        r = 1'b1; tick = 1'b1; mem_rdata = '0;
        #1;
        check_all_zero("abort");
        @(posedge clk); #1;
        r = 1'b0; tick = 1'b0;
        @(negedge clk);
        check_all_zero("abort_release");
        idle_cycles(3);

        for (int t = 0; t < 20; t++) begin
            run_xfer(6'($urandom), 6'($urandom), 1'($urandom),
                     int'($urandom_range(1, 4)), 1'($urandom));
        end
        idle_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
